// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 RV32M/RV64M multiply/divide execute unit.
// One operation in flight; result returned over a valid/ready handshake.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow
// and multiply-by-zero skip the iteration and land in DONE on the accept edge.
module mul_div_unit #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        flush,
  input  logic                        startValid,
  output logic                        startReady,
  input  logic [2:0]                  funct3,
  input  logic [XLEN-1:0]             rs1Data,
  input  logic [XLEN-1:0]             rs2Data,
  input  logic [$clog2(NUM_REGS)-1:0] rdAddrIn,
  output logic                        resultValid,
  input  logic                        resultReady,
  output logic [XLEN-1:0]             result,
  output logic [$clog2(NUM_REGS)-1:0] rdAddrOut
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, next_state;

  logic [CW-1:0]               counter;
  logic [2:0]                  op;
  logic [$clog2(NUM_REGS)-1:0] rd;
  logic [XLEN-1:0]             a_reg;
  logic [XLEN-1:0]             opb;
  logic [XLEN-1:0]             hi;
  logic [XLEN-1:0]             lo;
  logic                        neg_a;
  logic                        neg_b;
  logic                        special;
  logic                        div_zero;

  logic                        accept;
  logic                        last_iter;
  logic                        is_div_in;
  logic                        a_signed_in;
  logic                        b_signed_in;
  logic                        neg_a_in;
  logic                        neg_b_in;
  logic [XLEN-1:0]             mag_a_in;
  logic [XLEN-1:0]             mag_b_in;
  logic                        div_zero_in;
  logic                        ovf_in;
  logic                        early_in;
  logic [XLEN:0]               mul_sum;
  logic [XLEN:0]               shifted;
  logic [2*XLEN-1:0]           product;
  logic [2*XLEN-1:0]           product_fix;
  logic [XLEN-1:0]             quo_fix;
  logic [XLEN-1:0]             rem_fix;
  logic [XLEN-1:0]             fix_value;

  // Architectural results for divide-by-zero, signed overflow and zero product
  function automatic logic [XLEN-1:0] special_value(input logic [2:0] f,
                                                    input logic [XLEN-1:0] a,
                                                    input logic dz);
    if (!f[2])
      return '0;
    else if (dz)
      return f[1] ? a : '1;
    else
      return f[1] ? '0 : a;
  endfunction

  assign startReady  = (state == IDLE);
  assign resultValid = (state == DONE);
  assign accept      = startValid && startReady;
  assign last_iter   = (counter == CW'(XLEN - 1));

  // Decode the incoming request: signedness, operand magnitudes, special cases
  always_comb begin
    is_div_in   = funct3[2];
    a_signed_in = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed_in = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    neg_a_in    = a_signed_in && rs1Data[XLEN-1];
    neg_b_in    = b_signed_in && rs2Data[XLEN-1];
    mag_a_in    = neg_a_in ? -rs1Data : rs1Data;
    mag_b_in    = neg_b_in ? -rs2Data : rs2Data;
    div_zero_in = is_div_in && (rs2Data == '0);
    ovf_in      = is_div_in && !funct3[0] && (rs1Data == {1'b1, {(XLEN-1){1'b0}}})
                  && (rs2Data == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early_in    = div_zero_in || ovf_in || (!is_div_in && ((rs1Data == '0) || (rs2Data == '0)));
`else
    early_in    = 1'b0;
`endif
  end

  // One iteration step for each algorithm plus the final sign correction
  always_comb begin
    mul_sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    shifted     = {hi, lo[XLEN-1]};
    product     = {hi, lo};
    product_fix = (neg_a ^ neg_b) ? -product : product;
    quo_fix     = (neg_a ^ neg_b) ? -lo : lo;
    rem_fix     = neg_a ? -hi : hi;
    fix_value   = '0;
    if (special)
      fix_value = special_value(op, a_reg, div_zero);
    else if (op[2])
      fix_value = op[1] ? rem_fix : quo_fix;
    else if (op[1:0] == 2'd0)
      fix_value = product_fix[XLEN-1:0];
    else
      fix_value = product_fix[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic; flush overrides accept and the result handshake
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = early_in ? DONE : CALC;
      CALC:    if (last_iter) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    if (resultReady) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush)
      next_state = IDLE;
  end

  // Operand capture, shift-add / restoring-divide iterations and result register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      counter   <= '0;
      op        <= '0;
      rd        <= '0;
      a_reg     <= '0;
      opb       <= '0;
      hi        <= '0;
      lo        <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      special   <= 1'b0;
      div_zero  <= 1'b0;
      result    <= '0;
      rdAddrOut <= '0;
    end else if (flush) begin
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            counter  <= '0;
            op       <= funct3;
            rd       <= rdAddrIn;
            a_reg    <= rs1Data;
            neg_a    <= neg_a_in;
            neg_b    <= neg_b_in;
            special  <= div_zero_in || ovf_in;
            div_zero <= div_zero_in;
            hi       <= '0;
            lo       <= is_div_in ? mag_a_in : mag_b_in;
            opb      <= is_div_in ? mag_b_in : mag_a_in;
            if (early_in) begin
              result    <= special_value(funct3, rs1Data, div_zero_in);
              rdAddrOut <= rdAddrIn;
            end
          end
        end
        CALC: begin
          counter <= counter + CW'(1);
          if (op[2]) begin
            if (shifted >= {1'b0, opb}) begin
              hi <= XLEN'(shifted - {1'b0, opb});
              lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
              hi <= shifted[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b0};
            end
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
        end
        FIX: begin
          result    <= fix_value;
          rdAddrOut <= rd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic        startValid;
  logic        startReady;
  logic [2:0]  funct3;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [4:0]  rdAddrIn;
  logic        resultValid;
  logic        resultReady;
  logic [31:0] result;
  logic [4:0]  rdAddrOut;

  int nChecks = 0;
  int nFail   = 0;
  bit busySeen;

  mul_div_unit #(.XLEN(32), .NUM_REGS(32)) dut (
    .clk(clk), .rstN(rstN), .flush(flush),
    .startValid(startValid), .startReady(startReady),
    .funct3(funct3), .rs1Data(rs1Data), .rs2Data(rs2Data), .rdAddrIn(rdAddrIn),
    .resultValid(resultValid), .resultReady(resultReady),
    .result(result), .rdAddrOut(rdAddrOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the RISC-V M-extension arithmetic rules
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ub, p;
    longint unsigned pu;
    int              ia, ib;
    logic [63:0]     bits;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = a;
    ib = b;
    case (f)
      3'd0: begin pu = {32'h0, a} * {32'h0, b}; bits = pu; return bits[31:0]; end
      3'd1: begin p = sa * sb; bits = p; return bits[63:32]; end
      3'd2: begin p = sa * ub; bits = p; return bits[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; bits = pu; return bits[63:32]; end
      3'd4: if (b == 0) return ONES; else if (a == MINV && b == ONES) return a; else return ia / ib;
      3'd5: if (b == 0) return ONES; else return a / b;
      3'd6: if (b == 0) return a; else if (a == MINV && b == ONES) return 0; else return ia % ib;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (f[2] && (b == 0 || (!f[0] && a == MINV && b == ONES))) return 0;
    if (!f[2] && (a == 0 || b == 0)) return 0;
`endif
    return XLEN + 1;
  endfunction

  task automatic startOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    funct3     = f;
    rs1Data    = a;
    rs2Data    = b;
    rdAddrIn   = rd;
    startValid = 1'b1;
    @(posedge clk);
    #1;
    startValid = 1'b0;
    rs1Data    = $urandom;
    rs2Data    = $urandom;
    rdAddrIn   = 5'($urandom);
  endtask

  task automatic waitValid(output int edges);
    edges    = 0;
    busySeen = 1'b0;
    while (!resultValid && edges < 200) begin
      if (startReady) busySeen = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    if (!resultValid) checkOutput("timeout", edges, XLEN + 1);
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int edges;
    resultReady = 1'b1;
    startOp(f, a, b, rd);
    waitValid(edges);
    checkOutput($sformatf("latency f%0d", f), edges, expLatency(f, a, b));
    checkOutput($sformatf("result f%0d %h %h", f, a, b), result, refModel(f, a, b));
    checkOutput("rdAddrOut", rdAddrOut, rd);
    checkOutput("busy_startReady", busySeen, 0);
    @(posedge clk);
    #1;
    checkOutput("post_handshake_ready", {startReady, resultValid}, 2'b10);
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] corner [5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = ONES;
    corner[3] = MINV;  corner[4] = 32'h7FFF_FFFF;
    if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin
    int   edges;
    bit   stable;
    bit   validSeen;
    logic [31:0] held;

    rstN = 1'b0; flush = 1'b0; startValid = 1'b0; resultReady = 1'b1;
    funct3 = '0; rs1Data = '0; rs2Data = '0; rdAddrIn = '0;
    #2;
    checkOutput("reset_state", {startReady, resultValid, rdAddrOut, result}, {1'b1, 1'b0, 5'd0, 32'd0});
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9);
    applyStimulus(3'd1, MINV, MINV, 5'd1);
    applyStimulus(3'd3, MINV, MINV, 5'd2);
    applyStimulus(3'd2, ONES, 32'd2, 5'd3);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5);
    applyStimulus(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd6);
    applyStimulus(3'd5, 32'd5, 32'd0, 5'd7);
    applyStimulus(3'd7, 32'd5, 32'd0, 5'd8);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd10);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd11);
    applyStimulus(3'd4, MINV, ONES, 5'd12);
    applyStimulus(3'd6, MINV, ONES, 5'd13);
    applyStimulus(3'd0, 32'd0, 32'd1234, 5'd14);

    for (int i = 0; i < 40; i++)
      applyStimulus(3'($urandom_range(7)), pickOperand(), pickOperand(), 5'($urandom_range(31)));

    // Backpressure: result must hold while writeback stalls
    resultReady = 1'b0;
    startOp(3'd4, 32'd1000, 32'd7, 5'd17);
    waitValid(edges);
    held   = result;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!resultValid || startReady || result !== held || rdAddrOut !== 5'd17) stable = 1'b0;
    end
    checkOutput("bp_result", held, refModel(3'd4, 32'd1000, 32'd7));
    checkOutput("bp_hold", stable, 1);
    resultReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release", {startReady, resultValid}, 2'b10);

    // Flush part way through a divide
    startOp(3'd4, 32'd123456, 32'd77, 5'd20);
    repeat (12) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_idle", {startReady, resultValid}, 2'b10);
    validSeen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (resultValid) validSeen = 1'b1;
    end
    checkOutput("flush_no_result", validSeen, 0);

    // Asynchronous reset part way through a multiply
    startOp(3'd0, 32'd99, 32'd101, 5'd21);
    repeat (20) begin @(posedge clk); #1; end
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midop_reset", {startReady, resultValid, rdAddrOut, result}, {1'b1, 1'b0, 5'd0, 32'd0});
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(3'd0, 32'd3, 32'd4, 5'd22);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
